// File: rtl/mem_agent_pkg.sv
// Shared types and constants for the mem_agent write-then-readback engine.
package mem_agent_pkg;

  localparam int ERR_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GAP,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  // Error counter increment that sticks at all-ones.
  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (v == {ERR_WIDTH{1'b1}}) ? v : v + {{(ERR_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mem_agent_checker.sv
// Read-latency pipeline carrying expected data/address alongside each read,
// plus the comparator and error bookkeeping.
module mem_agent_checker
  import mem_agent_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_exp,
  input  logic [DATA_WIDTH-1:0] rddata,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] exp_q  [RD_LATENCY];
  logic [DATA_WIDTH-1:0] exp_d  [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] addr_q [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] addr_d [RD_LATENCY];
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;
  logic                  mismatch_s;

  always_comb begin
    vld_d[0]  = rd_vld;
    exp_d[0]  = rd_exp;
    addr_d[0] = rd_addr;
    for (int j = 1; j < RD_LATENCY; j++) begin
      vld_d[j]  = vld_q[j-1];
      exp_d[j]  = exp_q[j-1];
      addr_d[j] = addr_q[j-1];
    end
    // The last stage lines up with rddata for the read issued RD_LATENCY cycles ago.
    mismatch_s = vld_q[RD_LATENCY-1] && (rddata != exp_q[RD_LATENCY-1]);
    err_d   = err_q;
    first_d = first_q;
    if (clear) begin
      err_d   = '0;
      first_d = '0;
    end else if (mismatch_s) begin
      err_d = sat_inc(err_q);
      if (err_q == '0) begin
        first_d = addr_q[RD_LATENCY-1];
      end else begin
        first_d = first_q;
      end
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      for (int j = 0; j < RD_LATENCY; j++) begin
        exp_q[j]  <= '0;
        addr_q[j] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      exp_q   <= exp_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: rtl/mem_agent.sv
// Memory test agent: writes seed+i to base+i, reads the range back and
// counts mismatches against the regenerated pattern.
module mem_agent
  import mem_agent_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  wren,
  output logic [ADDR_WIDTH-1:0] wraddr,
  output logic [DATA_WIDTH-1:0] wrdata,
  output logic                  rden,
  output logic [ADDR_WIDTH-1:0] rdaddr,
  input  logic [DATA_WIDTH-1:0] rddata
);

  localparam logic [ADDR_WIDTH:0] IDX_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [3:0]          DRAIN_LAST = 4'(RD_LATENCY - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [3:0]            drain_q, drain_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  wren_q, wren_d, rden_q, rden_d;
  logic [ADDR_WIDTH-1:0] wraddr_q, wraddr_d, rdaddr_q, rdaddr_d;
  logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d, rdexp_q, rdexp_d;
  logic [ADDR_WIDTH-1:0] word_addr_s;
  logic [DATA_WIDTH-1:0] word_data_s;
  logic                  clear_s;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    base_d   = base_q;
    seed_d   = seed_q;
    drain_d  = drain_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wren_d   = 1'b0;
    wraddr_d = '0;
    wrdata_d = '0;
    rden_d   = 1'b0;
    rdaddr_d = '0;
    rdexp_d  = '0;
    clear_s  = 1'b0;
    word_addr_s = base_q + idx_q[ADDR_WIDTH-1:0];
    word_data_s = seed_q + DATA_WIDTH'(idx_q);
    // Outputs are computed for the next state so they come straight from flops.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = length;
          seed_d  = seed;
          clear_s = 1'b1;
          busy_d  = 1'b1;
          if (length == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_WRITE;
            wren_d   = 1'b1;
            wraddr_d = base_addr;
            wrdata_d = seed;
            idx_d    = IDX_ONE;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      S_WRITE: begin
        if (idx_q == len_q) begin
          state_d = S_GAP;
        end else begin
          wren_d   = 1'b1;
          wraddr_d = word_addr_s;
          wrdata_d = word_data_s;
          idx_d    = idx_q + IDX_ONE;
        end
      end
      S_GAP: begin
        state_d  = S_READ;
        rden_d   = 1'b1;
        rdaddr_d = base_q;
        rdexp_d  = seed_q;
        idx_d    = IDX_ONE;
      end
      S_READ: begin
        if (idx_q == len_q) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          rden_d   = 1'b1;
          rdaddr_d = word_addr_s;
          rdexp_d  = word_data_s;
          idx_d    = idx_q + IDX_ONE;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      base_q   <= '0;
      seed_q   <= '0;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      rden_q   <= 1'b0;
      rdaddr_q <= '0;
      rdexp_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      base_q   <= base_d;
      seed_q   <= seed_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
      rden_q   <= rden_d;
      rdaddr_q <= rdaddr_d;
      rdexp_q  <= rdexp_d;
    end
  end

  mem_agent_checker #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .RD_LATENCY(RD_LATENCY)
  ) u_checker (
    .clk           (aclk),
    .rst_n         (aresetn),
    .clear         (clear_s),
    .rd_vld        (rden_q),
    .rd_addr       (rdaddr_q),
    .rd_exp        (rdexp_q),
    .rddata        (rddata),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign wren   = wren_q;
  assign wraddr = wraddr_q;
  assign wrdata = wrdata_q;
  assign rden   = rden_q;
  assign rdaddr = rdaddr_q;

endmodule

// File: tb/tb_mem_agent.sv
// Randomized bench for mem_agent with a RAM model that can corrupt chosen
// addresses and a per-run reference built from the address/data rules.
module tb_mem_agent;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int L  = 2;

  logic          aclk = 1'b0;
  logic          aresetn, start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [DW-1:0] seed;
  logic          busy, done, wren, rden;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr, wraddr, rdaddr;
  logic [DW-1:0] wrdata, rddata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem     [1<<AW];
  logic [DW-1:0] corrupt [1<<AW];
  logic [DW-1:0] pipe    [L];

  always #5 aclk = ~aclk;

  mem_agent #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .base_addr(base_addr),
    .length(length), .seed(seed), .busy(busy), .done(done),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
    .rden(rden), .rdaddr(rdaddr), .rddata(rddata)
  );

  // RAM with fixed read latency; corrupt[] flips bits on the way out.
  always @(posedge aclk) begin
    if (wren) mem[wraddr] <= wrdata;
    for (int j = L - 1; j > 0; j--) pipe[j] <= pipe[j-1];
    pipe[0] <= rden ? (mem[rdaddr] ^ corrupt[rdaddr]) : 32'hDEAD_BEEF;
  end
  assign rddata = pipe[L-1];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_corrupt();
    for (int a = 0; a < (1 << AW); a++) corrupt[a] = 32'h0;
  endtask

  // Caller must be just past a negedge; start is sampled at the next posedge.
  task automatic run(input logic [AW-1:0] b, input logic [AW:0] len,
                     input logic [DW-1:0] s, input bit glitch, input int abort_at);
    logic [AW+DW-1:0] wq[$];
    logic [AW-1:0]    rq[$];
    logic [AW+DW-1:0] e;
    logic [AW-1:0]    a, exp_first;
    int               exp_err, exp_done;
    bit               seen;
    exp_err = 0; exp_first = '0; seen = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      a = AW'(int'(b) + i);
      wq.push_back({a, DW'(s + DW'(i))});
      rq.push_back(a);
      if (corrupt[a] != 32'h0) begin
        if (exp_err == 0) exp_first = a;
        if (exp_err < 65535) exp_err++;
      end
    end
    exp_done = (len == 0) ? 1 : 2 * int'(len) + L + 2;

    base_addr = b; length = len; seed = s; start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0; base_addr = AW'($urandom); length = (AW+1)'($urandom); seed = $urandom;

    for (int n = 1; n <= exp_done + 8; n++) begin
      @(negedge aclk);
      if (glitch && n == 2) start = 1'b1;
      if (glitch && n == 3) start = 1'b0;
      if (abort_at > 0 && n == abort_at) begin
        aresetn = 1'b0;
        @(posedge aclk); #1;
        check_eq("rst_outputs", {busy, done, wren, rden, wraddr, rdaddr}, 64'h0);
        check_eq("rst_wrdata", wrdata, 64'h0);
        check_eq("rst_err", {err_count, first_err_addr}, 64'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int k = 0; k < 2 * L + 2; k++) begin
          @(negedge aclk);
          check_eq("abort_quiet", {busy, done, err_count, first_err_addr}, 64'h0);
        end
        return;
      end
      if (wren) begin
        if (wq.size() == 0) check_eq("wr_extra", 64'd1, 64'd0);
        else begin
          e = wq.pop_front();
          check_eq("wraddr", wraddr, e[AW+DW-1:DW]);
          check_eq("wrdata", wrdata, e[DW-1:0]);
        end
      end else check_eq("wr_idle_zero", {wraddr, wrdata}, 64'h0);
      if (rden) begin
        if (rq.size() == 0) check_eq("rd_extra", 64'd1, 64'd0);
        else check_eq("rdaddr", rdaddr, rq.pop_front());
      end else check_eq("rd_idle_zero", rdaddr, 64'h0);
      if (done) begin
        check_eq("done_cycle", n, exp_done);
        check_eq("busy_at_done", busy, 64'd1);
        check_eq("err_count", err_count, exp_err);
        check_eq("first_err_addr", first_err_addr, exp_first);
        seen = 1'b1;
        break;
      end
      check_eq("busy_during_run", busy, 64'd1);
    end
    if (!seen) check_eq("done_timeout", 64'd0, 64'd1);
    check_eq("writes_left", wq.size(), 64'd0);
    check_eq("reads_left", rq.size(), 64'd0);

    if (glitch) start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    check_eq("idle_after_done", {busy, done}, 64'h0);
    @(negedge aclk);
    check_eq("idle_no_restart", {busy, wren, rden}, 64'h0);
    check_eq("err_hold", {err_count, first_err_addr}, {exp_err[15:0], exp_first});
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    logic [AW:0] len;
    aresetn = 1'b0; start = 1'b0; base_addr = '0; length = '0; seed = '0;
    clear_corrupt();
    for (int j = 0; j < L; j++) pipe[j] = 32'h0;
    repeat (3) @(negedge aclk);
    check_eq("reset_state", {busy, done, wren, rden, wraddr, rdaddr, err_count}, 64'h0);
    aresetn = 1'b1;

    run(8'h10, 9'd4, 32'h100, 1'b0, 0);
    run(8'hFE, 9'd4, 32'hFFFF_FFFE, 1'b0, 0);
    corrupt[8'h12] = 32'h1;
    corrupt[8'h13] = 32'h8000_0000;
    run(8'h10, 9'd4, 32'h100, 1'b0, 0);
    clear_corrupt();
    run(8'h33, 9'd0, 32'h5, 1'b0, 0);
    run(8'h40, 9'd6, 32'hABC, 1'b1, 0);
    corrupt[8'h80] = 32'h4;
    run(8'h80, 9'd8, 32'h77, 1'b0, 8 + 3);
    clear_corrupt();
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    run(8'h20, 9'd3, 32'h1234, 1'b0, 0);
    run(8'h00, 9'd256, 32'hFFFF_FF00, 1'b0, 0);

    for (int r = 0; r < 25; r++) begin
      clear_corrupt();
      k = int'($urandom_range(0, 3));
      for (int c = 0; c < k; c++) corrupt[$urandom_range(0, 255)] = $urandom | 32'h1;
      case ($urandom_range(0, 7))
        0: len = 9'd0;
        1: len = 9'd1;
        2: len = 9'd256;
        default: len = 9'($urandom_range(2, 40));
      endcase
      run(AW'($urandom), len, $urandom, (len >= 9'd4) && $urandom_range(0, 1) == 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_agent.md
MEM_AGENT -- requirements
Module: mem_agent

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, RAM address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM data width in bits.
REQ-003 SHALL have parameter RD_LATENCY, default 2, cycles from rden to valid rddata on the RAM read port (legal range 1..8).
REQ-004 SHALL have port aclk  input  1  single clock.
REQ-005 SHALL have port aresetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  request a write-then-readback run; sampled only in IDLE.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  first address of the run.
REQ-008 SHALL have port length  input  ADDR_WIDTH+1  number of words, 0..2**ADDR_WIDTH.
REQ-009 SHALL have port seed  input  DATA_WIDTH  pattern seed.
REQ-010 SHALL have port busy  output  1  high from start acceptance until the done cycle inclusive.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-012 SHALL have port err_count  output  16  mismatches in the current or last run.
REQ-013 SHALL have port first_err_addr  output  ADDR_WIDTH  address of the first mismatch.
REQ-014 SHALL have ports wren (1), wraddr (ADDR_WIDTH), wrdata (DATA_WIDTH)  outputs  one RAM write port.
REQ-015 SHALL have ports rden (1), rdaddr (ADDR_WIDTH) outputs and rddata (DATA_WIDTH) input  one RAM read port.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, GAP, READ, DRAIN, DONE.
REQ-017 SHALL, in IDLE with start=1, latch base_addr, length, seed, clear err_count and first_err_addr, and enter WRITE (or DONE directly if length=0).
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL, in WRITE, assert wren for exactly length consecutive cycles with wraddr=base+i, wrdata=seed+i, i=0..length-1.
REQ-020 SHALL wrap address arithmetic modulo 2**ADDR_WIDTH and data arithmetic modulo 2**DATA_WIDTH.
REQ-021 SHALL spend exactly one cycle in GAP with wren=rden=0.
REQ-022 SHALL, in READ, assert rden for exactly length consecutive cycles with rdaddr=base+i in the same order.
REQ-023 SHALL compare rddata exactly RD_LATENCY cycles after each rden against the expected seed+i carried in a RD_LATENCY-deep pipeline.
REQ-024 SHALL remain in DRAIN until all outstanding compares complete (RD_LATENCY cycles after last rden), then enter DONE.
REQ-025 SHALL, in DONE, pulse done=1 for one cycle and return to IDLE the next cycle.
REQ-026 SHALL increment err_count per mismatch, saturating at 16'hFFFF.
REQ-027 SHALL capture first_err_addr only on the mismatch that moves err_count from 0 to 1.
REQ-028 SHALL hold err_count and first_err_addr stable in IDLE until the next accepted start.
REQ-029 SHALL drive wraddr, wrdata, rdaddr to 0 whenever the corresponding enable is 0.
REQ-030 SHALL, for length=2**ADDR_WIDTH, cover every address exactly once per phase.

Reset
REQ-031 SHALL, with aresetn=0 at a rising aclk edge, force state IDLE and all outputs to 0, including err_count and first_err_addr.
REQ-032 SHALL discard all in-flight compares on reset mid-run; no done pulse is generated for the aborted run.
REQ-033 SHALL accept start on the first cycle after aresetn returns high.

Structure
REQ-034 SHALL take the FSM state enum and the ERR_WIDTH=16 constant from package mem_agent_pkg.
REQ-035 SHALL place the expected-data/valid latency pipeline and comparator in sub-module mem_agent_checker.
REQ-036 SHALL contain no memory; only counters, FSM and the RD_LATENCY pipeline.

Verification
REQ-037 SHALL cover: base=0x10, length=4, seed=0x100 on ideal RAM -> writes 0x100..0x103 to 0x10..0x13, reads same, done after 4+1+4+RD_LATENCY+1 cycles from start, err_count=0.
REQ-038 SHALL cover: base=0xFE, length=4 -> addresses 0xFE,0xFF,0x00,0x01 in both phases.
REQ-039 SHALL cover: RAM model corrupting word at 0x12 and 0x13 -> err_count=2, first_err_addr=0x12.
REQ-040 SHALL cover: length=0 -> no wren/rden, busy high one cycle, done pulse next cycle, err_count=0.
REQ-041 SHALL cover: aresetn low during READ with a mismatch pending -> all outputs 0 next cycle, no done, err_count=0.
REQ-042 SHALL cover: start pulsed during WRITE and while done=1 -> ignored; run parameters unchanged.
